// File: rtl/m_std_divider.sv
// rtl/m_std_divider.sv - radix-2 restoring divider for RV32M div/divu/rem/remu
// Optional M_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration loop.
module m_std_divider #(
    parameter int INPUT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   STALL_DIV,
    input  logic                   START,
    input  logic                   SIGN,
    input  logic [INPUT_WIDTH-1:0] DIVIDEND,
    input  logic [INPUT_WIDTH-1:0] DIVIDER,
    output logic [INPUT_WIDTH-1:0] QUOTIENT_OUT,
    output logic [INPUT_WIDTH-1:0] REMAINDER_OUT,
    output logic                   READY
);

    localparam int CW = $clog2(INPUT_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(INPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [INPUT_WIDTH-1:0] quo;
    logic [INPUT_WIDTH-1:0] rem;
    logic [INPUT_WIDTH-1:0] divisor;
    logic [CW-1:0]          cnt;
    logic                   neg_q;
    logic                   neg_r;
    logic                   dz;

    logic                   accept;
    logic                   special;
    logic                   dividend_neg;
    logic                   divider_neg;
    logic                   dz_in;
    logic [INPUT_WIDTH-1:0] dividend_mag;
    logic [INPUT_WIDTH-1:0] divider_mag;
    logic [INPUT_WIDTH:0]   shifted;
    logic [INPUT_WIDTH:0]   trial;

    assign dividend_neg = SIGN & DIVIDEND[INPUT_WIDTH-1];
    assign divider_neg  = SIGN & DIVIDER[INPUT_WIDTH-1];
    assign dividend_mag = dividend_neg ? -DIVIDEND : DIVIDEND;
    assign divider_mag  = divider_neg ? -DIVIDER : DIVIDER;
    assign dz_in        = (DIVIDER == '0);

`ifdef M_DIV_FAST_SPECIAL_EN
    logic ovf_in;
    assign ovf_in  = SIGN & (DIVIDEND == {1'b1, {(INPUT_WIDTH-1){1'b0}}}) & (DIVIDER == '1);
    assign special = dz_in | ovf_in;
`else
    assign special = 1'b0;
`endif

    // Partial remainder stays below the divisor, so W+1 bits hold the trial and its sign.
    assign shifted = {rem, quo[INPUT_WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (!STALL_DIV) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        accept    = 1'b1;
                        state_nxt = special ? S_FIX : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == LAST_ITER) begin
                        state_nxt = S_FIX;
                    end
                end
                S_FIX:   state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            quo           <= '0;
            rem           <= '0;
            divisor       <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            QUOTIENT_OUT  <= '0;
            REMAINDER_OUT <= '0;
            READY         <= 1'b0;
        end else if (!STALL_DIV) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        divisor <= divider_mag;
                        neg_q   <= SIGN & (DIVIDEND[INPUT_WIDTH-1] ^ DIVIDER[INPUT_WIDTH-1]);
                        neg_r   <= dividend_neg;
                        dz      <= dz_in;
                        cnt     <= '0;
                        READY   <= 1'b0;
`ifdef M_DIV_FAST_SPECIAL_EN
                        // Preload the magnitudes the loop would have produced.
                        if (dz_in) begin
                            quo <= '1;
                            rem <= dividend_mag;
                        end else begin
                            quo <= dividend_mag;
                            rem <= '0;
                        end
`else
                        quo <= dividend_mag;
                        rem <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[INPUT_WIDTH]) begin
                        rem <= trial[INPUT_WIDTH-1:0];
                        quo <= {quo[INPUT_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[INPUT_WIDTH-1:0];
                        quo <= {quo[INPUT_WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    QUOTIENT_OUT  <= (neg_q & !dz) ? -quo : quo;
                    REMAINDER_OUT <= neg_r ? -rem : rem;
                    READY         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_std_divider.sv
// tb/tb_m_std_divider.sv - directed and randomized checks of m_std_divider against an arithmetic model
module tb_m_std_divider;

    logic        CLK;
    logic        RST;
    logic        STALL_DIV;
    logic        START;
    logic        SIGN;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVIDER;
    logic [31:0] QUOTIENT_OUT;
    logic [31:0] REMAINDER_OUT;
    logic        READY;

    int checks = 0;
    int errors = 0;

    m_std_divider #(.INPUT_WIDTH(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .STALL_DIV    (STALL_DIV),
        .START        (START),
        .SIGN         (SIGN),
        .DIVIDEND     (DIVIDEND),
        .DIVIDER      (DIVIDER),
        .QUOTIENT_OUT (QUOTIENT_OUT),
        .REMAINDER_OUT(REMAINDER_OUT),
        .READY        (READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics from plain 64-bit arithmetic.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_latency(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef M_DIV_FAST_SPECIAL_EN
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        int cycles;
        model(s, a, b, eq, er);
        @(negedge CLK);
        SIGN     = s;
        DIVIDEND = a;
        DIVIDER  = b;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        cycles = 0;
        check({tag, "_ready_drop"}, 32'(READY), 32'd0);
        while (!READY && cycles < 100) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_latency(s, a, b)));
        check({tag, "_q"}, QUOTIENT_OUT, eq);
        check({tag, "_r"}, REMAINDER_OUT, er);
    endtask

    initial begin
        int cycles;
        int sel;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        RST       = 1'b1;
        STALL_DIV = 1'b0;
        START     = 1'b0;
        SIGN      = 1'b0;
        DIVIDEND  = '0;
        DIVIDER   = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset_ready", 32'(READY), 32'd0);
        check("reset_q", QUOTIENT_OUT, 32'd0);
        check("reset_r", REMAINDER_OUT, 32'd0);

        run_op("unsigned_100_7", 1'b0, 32'd100, 32'd7);
        check("tp_unsigned_q", QUOTIENT_OUT, 32'd14);
        check("tp_unsigned_r", REMAINDER_OUT, 32'd2);
        repeat (4) @(posedge CLK);
        #1;
        check("hold_ready", 32'(READY), 32'd1);
        check("hold_q", QUOTIENT_OUT, 32'd14);

        run_op("signed_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("tp_signed_q", QUOTIENT_OUT, 32'hFFFF_FFFD);
        check("tp_signed_r", REMAINDER_OUT, 32'hFFFF_FFFF);

        run_op("dz_signed", 1'b1, 32'h8000_0005, 32'd0);
        check("tp_dz_q", QUOTIENT_OUT, 32'hFFFF_FFFF);
        check("tp_dz_r", REMAINDER_OUT, 32'h8000_0005);
        run_op("dz_unsigned", 1'b0, 32'h8000_0005, 32'd0);

        run_op("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("tp_ovf_q", QUOTIENT_OUT, 32'h8000_0000);
        check("tp_ovf_r", REMAINDER_OUT, 32'd0);

        // Stall in BUSY plus an ignored second START.
        @(negedge CLK);
        SIGN     = 1'b0;
        DIVIDEND = 32'd1000;
        DIVIDER  = 32'd10;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        cycles = 0;
        check("old_result_kept_q", QUOTIENT_OUT, 32'h8000_0000);
        repeat (3) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        DIVIDEND = 32'd9;
        DIVIDER  = 32'd3;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        cycles++;
        START     = 1'b0;
        STALL_DIV = 1'b1;
        repeat (5) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        STALL_DIV = 1'b0;
        check("stall_not_ready", 32'(READY), 32'd0);
        while (!READY && cycles < 200) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        check("stall_latency", 32'(cycles), 32'd38);
        check("stall_q", QUOTIENT_OUT, 32'd100);
        check("stall_r", REMAINDER_OUT, 32'd0);

        // Stall in DONE: START must not be sampled.
        STALL_DIV = 1'b1;
        START     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        START     = 1'b0;
        STALL_DIV = 1'b0;
        check("stall_done_ready", 32'(READY), 32'd1);
        check("stall_done_q", QUOTIENT_OUT, 32'd100);

        // Reset in the middle of BUSY.
        @(negedge CLK);
        DIVIDEND = 32'd1000;
        DIVIDER  = 32'd10;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst_ready", 32'(READY), 32'd0);
        check("midrst_q", QUOTIENT_OUT, 32'd0);
        check("midrst_r", REMAINDER_OUT, 32'd0);
        run_op("after_rst_9_3", 1'b0, 32'd9, 32'd3);
        check("tp_after_rst_q", QUOTIENT_OUT, 32'd3);

        for (int i = 0; i < 24; i++) begin
            rs  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 5));
            ra  = $urandom;
            case (sel)
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'd0;
                3: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d", i), rs, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
